// File: rtl/bsg_print_stat_logger_pkg.sv
`default_nettype none
//==============================================================================
// Module      : bsg_print_stat_pkg
// Description : Shared types for the print-stat interval logger. Provides the
//               event-type encoding of tag[31:30], the tag field positions, a
//               helper for the tag-id width, and a macro that builds the packed
//               interval-record struct for given counter and tag-id widths.
// Revision    : 1.0 - initial release
//==============================================================================

// Interval record: kernel flag, tag id, start timestamp, elapsed cycles.
// The kernel flag is the MSB so the packed order matches the host's view.
`ifndef BSG_PRINT_STAT_REC_S
`define BSG_PRINT_STAT_REC_S(ctr_w, id_w) \
  struct packed { \
    logic                kernel; \
    logic [(id_w)-1:0]   tag_id; \
    logic [(ctr_w)-1:0]  start; \
    logic [(ctr_w)-1:0]  cycles; \
  }
`endif

package bsg_print_stat_pkg;

  typedef enum logic [1:0] {
    e_kernel_start = 2'd0,
    e_kernel_end   = 2'd1,
    e_tag_start    = 2'd2,
    e_tag_end      = 2'd3
  } print_stat_type_e;

  localparam int c_type_msb = 31;
  localparam int c_type_lsb = 30;
  localparam int c_id_lsb   = 0;

  // A single tag slot still needs a one-bit id field to stay a legal vector.
  function automatic int tag_id_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_print_stat_logger_if.sv
`default_nettype none
//==============================================================================
// Module      : bsg_print_stat_logger_if
// Description : Record drain channel between the logger and the host side.
//               valid/ready handshake plus the record payload.
//   v / ready           : record available / host accepts it
//   rec_kernel          : 1 = kernel record, 0 = user-tag record
//   rec_tag_id          : tag id (0 for kernel records)
//   rec_start           : counter value at the start event
//   rec_cycles          : end counter minus start counter
// Revision    : 1.0 - initial release
//==============================================================================
interface bsg_print_stat_logger_if #(
  parameter int ctr_width_p    = 64,
  parameter int tag_id_width_p = 4
);
  logic                      v;
  logic                      ready;
  logic                      rec_kernel;
  logic [tag_id_width_p-1:0] rec_tag_id;
  logic [ctr_width_p-1:0]    rec_start;
  logic [ctr_width_p-1:0]    rec_cycles;

  modport master (
    output v, rec_kernel, rec_tag_id, rec_start, rec_cycles,
    input  ready
  );

  modport slave (
    input  v, rec_kernel, rec_tag_id, rec_start, rec_cycles,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/bsg_print_stat_logger_record_fifo.sv
`default_nettype none
//==============================================================================
// Module      : bsg_print_stat_record_fifo
// Description : Two-pointer 1r1w FIFO of interval records. The head entry is
//               held in an output register that reads 0 while empty. A push on
//               a full FIFO is accepted only when a pop happens that cycle.
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   v_i, data_i         : push request and record
//   yumi_i              : consumer takes the head (ignored when empty)
//   data_o              : head record (0 when empty)
//   full_o, empty_o     : occupancy flags
// Revision    : 1.0 - initial release
//==============================================================================
module bsg_print_stat_record_fifo
  import bsg_print_stat_pkg::*;
#(
  parameter int els_p          = 8,
  parameter int ctr_width_p    = 64,
  parameter int tag_id_width_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   v_i,
  input  logic [1+tag_id_width_p+2*ctr_width_p-1:0] data_i,
  input  logic                                   yumi_i,
  output logic [1+tag_id_width_p+2*ctr_width_p-1:0] data_o,
  output logic                                   full_o,
  output logic                                   empty_o
);

  typedef `BSG_PRINT_STAT_REC_S(ctr_width_p, tag_id_width_p) rec_t;

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  rec_t                mem_q [els_p];
  rec_t                head_q, head_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign data_o  = head_q;

  always_comb begin
    pop     = yumi_i & ~empty_o;
    push    = v_i & (~full_o | pop);
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // The head register must always mirror the oldest stored entry. When the
    // last entry leaves, a simultaneous push becomes the new head directly.
    head_d = head_q;
    if (pop) begin
      if (count_q == cnt_w_lp'(1)) head_d = push ? rec_t'(data_i) : '0;
      else                         head_d = mem_q[ptr_inc(rptr_q)];
    end else if (empty_o && push) begin
      head_d = rec_t'(data_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage contents are don't-care while unoccupied, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rec_t'(data_i);
  end

endmodule
`default_nettype wire

// File: rtl/bsg_print_stat_logger.sv
`default_nettype none
//==============================================================================
// Module      : bsg_print_stat_logger
// Description : Pairs print-stat start/end events per tag slot and kernel
//               slot, forms {start, elapsed cycles} records and buffers them
//               for the host. Keeps saturating protocol-error and drop counts.
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   print_stat_v_i      : event present this cycle
//   print_stat_tag_i    : [31:30] event type, low bits tag id
//   global_ctr_i        : free-running cycle count
//   rec_if (master)     : record drain channel (valid/ready + payload)
//   open_mask_o         : open flags, MSB is the kernel slot
//   err_cnt_o           : protocol errors (saturating)
//   drop_cnt_o          : records dropped on a full FIFO (saturating)
// Revision    : 1.0 - initial release
//==============================================================================
module bsg_print_stat_logger
  import bsg_print_stat_pkg::*;
#(
  parameter int data_width_p    = 32,
  parameter int ctr_width_p     = 64,
  parameter int tag_els_p       = 16,
  parameter int fifo_els_p      = 8,
  parameter int err_ctr_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       print_stat_v_i,
  input  logic [data_width_p-1:0]    print_stat_tag_i,
  input  logic [ctr_width_p-1:0]     global_ctr_i,
  bsg_print_stat_logger_if.master    rec_if,
  output logic [tag_els_p:0]         open_mask_o,
  output logic [err_ctr_width_p-1:0] err_cnt_o,
  output logic [err_ctr_width_p-1:0] drop_cnt_o
);

  localparam int id_w_lp   = tag_id_width(tag_els_p);
  localparam int slot_w_lp = $clog2(tag_els_p + 1);
  localparam int rec_w_lp  = 1 + id_w_lp + 2 * ctr_width_p;

  typedef `BSG_PRINT_STAT_REC_S(ctr_width_p, id_w_lp) rec_t;

  logic [tag_els_p:0]         open_q, open_d;
  logic [ctr_width_p-1:0]     start_q [tag_els_p+1];
  logic [ctr_width_p-1:0]     start_d [tag_els_p+1];
  logic [err_ctr_width_p-1:0] err_cnt_q, err_cnt_d;
  logic [err_ctr_width_p-1:0] drop_cnt_q, drop_cnt_d;

  print_stat_type_e ev_type;
  logic [id_w_lp-1:0]   ev_id;
  logic [slot_w_lp-1:0] slot;
  logic                 is_kernel, is_start, slot_open;
  logic                 push, pop, drop, err_event;
  logic                 fifo_full, fifo_empty;
  rec_t                 rec_in, rec_out;
  logic                 unused_tag_bits;

  assign unused_tag_bits = ^print_stat_tag_i;

  always_comb begin
    ev_type   = print_stat_type_e'(print_stat_tag_i[c_type_msb:c_type_lsb]);
    ev_id     = (tag_els_p > 1) ? print_stat_tag_i[c_id_lsb +: id_w_lp] : '0;
    is_kernel = (ev_type == e_kernel_start) || (ev_type == e_kernel_end);
    is_start  = (ev_type == e_kernel_start) || (ev_type == e_tag_start);
    slot      = is_kernel ? slot_w_lp'(tag_els_p) : slot_w_lp'(ev_id);
    slot_open = open_q[slot];

    open_d    = open_q;
    start_d   = start_q;
    push      = 1'b0;
    err_event = 1'b0;
    rec_in    = '0;

    if (print_stat_v_i) begin
      if (is_start) begin
        // A repeated start restarts the interval and is flagged.
        open_d[slot]  = 1'b1;
        start_d[slot] = global_ctr_i;
        err_event     = slot_open;
      end else begin
        if (slot_open) begin
          open_d[slot]  = 1'b0;
          push          = 1'b1;
          rec_in.kernel = is_kernel;
          rec_in.tag_id = is_kernel ? '0 : ev_id;
          rec_in.start  = start_q[slot];
          // Modular subtraction handles a counter wrap inside the interval.
          rec_in.cycles = global_ctr_i - start_q[slot];
        end else begin
          err_event = 1'b1;
        end
        // Ending the kernel with user tags still open is also a protocol error;
        // the tag slots themselves are left alone.
        if (is_kernel && (|open_q[tag_els_p-1:0])) err_event = 1'b1;
      end
    end

    pop  = rec_if.ready & ~fifo_empty;
    drop = push & fifo_full & ~pop;

    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (err_event && (err_cnt_q != '1)) err_cnt_d  = err_cnt_q + 1'b1;
    if (drop && (drop_cnt_q != '1))     drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      open_q     <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i <= tag_els_p; i++) start_q[i] <= '0;
    end else begin
      open_q     <= open_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i <= tag_els_p; i++) start_q[i] <= start_d[i];
    end
  end

  logic [rec_w_lp-1:0] fifo_data_out;

  bsg_print_stat_record_fifo #(
    .els_p          (fifo_els_p),
    .ctr_width_p    (ctr_width_p),
    .tag_id_width_p (id_w_lp)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (push),
    .data_i    (rec_in),
    .yumi_i    (rec_if.ready),
    .data_o    (fifo_data_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rec_out           = rec_t'(fifo_data_out);
  assign rec_if.v          = ~fifo_empty;
  assign rec_if.rec_kernel = rec_out.kernel;
  assign rec_if.rec_tag_id = rec_out.tag_id;
  assign rec_if.rec_start  = rec_out.start;
  assign rec_if.rec_cycles = rec_out.cycles;

  assign open_mask_o = open_q;
  assign err_cnt_o   = err_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_print_stat_logger.sv
`default_nettype none
//==============================================================================
// Module      : tb_bsg_print_stat_logger
// Description : Directed self-checking bench for bsg_print_stat_logger with a
//               record scoreboard (expected records queued at stimulus time,
//               compared as the DUT hands them over).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_bsg_print_stat_logger;
  import bsg_print_stat_pkg::*;

  localparam logic [1:0] KS = 2'd0, KE = 2'd1, TS = 2'd2, TE = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps_v = 1'b0;
  logic [31:0] ps_tag = '0;
  logic [63:0] gctr = '0;
  logic [16:0] open_mask;
  logic [15:0] err_cnt, drop_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [136:0] exp_q [$];

  always #5 clk = ~clk;

  bsg_print_stat_logger_if #(.ctr_width_p(64), .tag_id_width_p(4)) rec_if ();

  bsg_print_stat_logger #(
    .data_width_p(32), .ctr_width_p(64), .tag_els_p(16),
    .fifo_els_p(8), .err_ctr_width_p(16)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .print_stat_v_i   (ps_v),
    .print_stat_tag_i (ps_tag),
    .global_ctr_i     (gctr),
    .rec_if           (rec_if),
    .open_mask_o      (open_mask),
    .err_cnt_o        (err_cnt),
    .drop_cnt_o       (drop_cnt)
  );

  function automatic logic [136:0] mk(input logic k, input logic [3:0] id,
                                      input logic [63:0] s, input logic [63:0] c);
    return {k, id, s, c};
  endfunction

  task automatic check(input string name, input logic [136:0] obs, input logic [136:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Called at posedge+1; event is sampled at the following posedge.
  task automatic ev(input logic [1:0] t, input logic [3:0] id, input logic [63:0] c);
    ps_v   = 1'b1;
    ps_tag = {t, 26'd0, id};
    gctr   = c;
    @(posedge clk); #1;
    ps_v   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    check("drain_empty", 137'(exp_q.size()), 137'd0);
  endtask

  // Scoreboard: every handed-over record must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rec_if.v && rec_if.ready) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_record: observed %0h expected none",
               {rec_if.rec_kernel, rec_if.rec_tag_id, rec_if.rec_start, rec_if.rec_cycles});
      end
      if (exp_q.size() != 0)
        check("record", {rec_if.rec_kernel, rec_if.rec_tag_id, rec_if.rec_start, rec_if.rec_cycles},
              exp_q.pop_front());
    end
  end

  function automatic logic [136:0] rec_now();
    return {rec_if.rec_kernel, rec_if.rec_tag_id, rec_if.rec_start, rec_if.rec_cycles};
  endfunction

  initial begin
    rec_if.ready = 1'b1;
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_v", 137'(rec_if.v), 137'd0);
    check("rst_open", 137'(open_mask), 137'd0);
    check("rst_err", 137'(err_cnt), 137'd0);
    check("rst_drop", 137'(drop_cnt), 137'd0);
    check("rst_rec", rec_now(), 137'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- tag interval ----------------
    ev(TS, 4'd3, 64'd100);
    check("t1_open", 137'(open_mask), 137'h8);
    check("t1_v_before", 137'(rec_if.v), 137'd0);
    exp_q.push_back(mk(1'b0, 4'd3, 64'd100, 64'd150));
    ev(TE, 4'd3, 64'd250);
    check("t1_v_after", 137'(rec_if.v), 137'd1);
    idle(1);
    check("t1_v_gone", 137'(rec_if.v), 137'd0);
    check("t1_closed", 137'(open_mask), 137'd0);

    // ---------------- kernel with nested tag ----------------
    ev(KS, 4'd0, 64'd10);
    ev(TS, 4'd0, 64'd20);
    exp_q.push_back(mk(1'b0, 4'd0, 64'd20, 64'd10));
    ev(TE, 4'd0, 64'd30);
    exp_q.push_back(mk(1'b1, 4'd0, 64'd10, 64'd80));
    ev(KE, 4'd0, 64'd90);
    drain(10);
    check("t2_err", 137'(err_cnt), 137'd0);

    // ---------------- protocol errors ----------------
    ev(TE, 4'd5, 64'd35);
    idle(1);
    check("t3_err1", 137'(err_cnt), 137'd1);
    check("t3_norec", 137'(rec_if.v), 137'd0);
    ev(TS, 4'd5, 64'd40);
    ev(TS, 4'd5, 64'd60);
    exp_q.push_back(mk(1'b0, 4'd5, 64'd60, 64'd10));
    ev(TE, 4'd5, 64'd70);
    check("t3_err2", 137'(err_cnt), 137'd2);
    drain(10);
    // kernel_end with a tag still open: record still formed, one error
    ev(KS, 4'd0, 64'd100);
    ev(TS, 4'd1, 64'd110);
    exp_q.push_back(mk(1'b1, 4'd0, 64'd100, 64'd50));
    ev(KE, 4'd9, 64'd150);
    check("t3_err3", 137'(err_cnt), 137'd3);
    check("t3_tag_kept", 137'(open_mask), 137'h2);
    exp_q.push_back(mk(1'b0, 4'd1, 64'd110, 64'd50));
    ev(TE, 4'd1, 64'd160);
    drain(10);
    check("t3_err_final", 137'(err_cnt), 137'd3);

    // ---------------- overflow with back-pressure ----------------
    rec_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ev(TS, 4'(i), 64'(1000 + 10 * i));
      if (i < 8) exp_q.push_back(mk(1'b0, 4'(i), 64'(1000 + 10 * i), 64'(i + 1)));
      ev(TE, 4'(i), 64'(1000 + 10 * i + i + 1));
    end
    ev(TS, 4'd10, 64'd5000);
    idle(2);
    check("t4_drop", 137'(drop_cnt), 137'd2);
    check("t4_v_held", 137'(rec_if.v), 137'd1);
    check("t4_head_stable", rec_now(), mk(1'b0, 4'd0, 64'd1000, 64'd1));
    check("t4_open", 137'(open_mask), 137'h400);
    // push on full while popping: accepted, nothing dropped
    rec_if.ready = 1'b1;
    exp_q.push_back(mk(1'b0, 4'd10, 64'd5000, 64'd7));
    ev(TE, 4'd10, 64'd5007);
    drain(20);
    check("t4_drop_same", 137'(drop_cnt), 137'd2);
    check("t4_v_low", 137'(rec_if.v), 137'd0);

    // ---------------- counter wrap ----------------
    ev(TS, 4'd7, 64'hFFFF_FFFF_FFFF_FFFB);
    exp_q.push_back(mk(1'b0, 4'd7, 64'hFFFF_FFFF_FFFF_FFFB, 64'd8));
    ev(TE, 4'd7, 64'd3);
    drain(10);

    // ---------------- asynchronous reset mid-flight ----------------
    rec_if.ready = 1'b0;
    ev(TS, 4'd1, 64'd200);
    ev(TS, 4'd2, 64'd210);
    ev(KS, 4'd0, 64'd220);
    for (int i = 0; i < 4; i++) begin
      ev(TS, 4'(4 + i), 64'(300 + i));
      ev(TE, 4'(4 + i), 64'(400 + i));
    end
    check("t6_pre_v", 137'(rec_if.v), 137'd1);
    check("t6_pre_open", 137'(open_mask), 137'h10006);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_v", 137'(rec_if.v), 137'd0);
    check("t6_async_open", 137'(open_mask), 137'd0);
    check("t6_async_err", 137'(err_cnt), 137'd0);
    check("t6_async_drop", 137'(drop_cnt), 137'd0);
    check("t6_async_rec", rec_now(), 137'd0);
    @(negedge clk); rst_n = 1'b1; rec_if.ready = 1'b1;
    @(posedge clk); #1;
    idle(3);
    check("t6_post_v", 137'(rec_if.v), 137'd0);
    check("t6_post_open", 137'(open_mask), 137'd0);
    check("t6_post_err", 137'(err_cnt), 137'd0);
    exp_q.push_back(mk(1'b0, 4'd2, 64'd1, 64'd3));
    ev(TS, 4'd2, 64'd1);
    ev(TE, 4'd2, 64'd4);
    drain(10);
    check("t6_final_drop", 137'(drop_cnt), 137'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
